// File: rtl/gpr_snapshot_fifo.sv
// Architectural-register snapshot FIFO between commit and the register checker.
// Captures GPRs, PC, changed mask and sequence number per retired instruction.
module gpr_snapshot_fifo #(
  parameter int NUM_GPRS  = 16,
  parameter int XLEN      = 32,
  parameter int DEPTH     = 4,
  parameter int DIFF_MODE = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     commit_valid,
  input  logic [XLEN-1:0]          commit_pc,
  input  logic [NUM_GPRS*XLEN-1:0] gprs,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [32*XLEN-1:0]       out_gprs,
  output logic [XLEN-1:0]          out_pc,
  output logic [31:0]              out_mask,
  output logic [31:0]              out_seq,
  output logic [$clog2(DEPTH):0]   count,
  output logic [15:0]              overflow_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]            wr_q, wr_d;
  logic [PW-1:0]            rd_q, rd_d;
  logic [NUM_GPRS*XLEN-1:0] shadow_q;
  logic [31:0]              seq_q;
  logic [15:0]              ovf_q;

  logic [32*XLEN-1:0] gprs_mem [DEPTH];
  logic [XLEN-1:0]    pc_mem   [DEPTH];
  logic [31:0]        mask_mem [DEPTH];
  logic [31:0]        seq_mem  [DEPTH];

  logic [31:0]        mask;
  logic [32*XLEN-1:0] gprs_pad;
  logic               full;
  logic               empty;
  logic               pop;
  logic               enq;
  logic               push;
  logic               drop;

  for (genvar i = 0; i < 32; i++) begin : g_mask
    if (i < NUM_GPRS) begin : g_live
      assign mask[i] =
        gprs[XLEN*i +: XLEN] != shadow_q[XLEN*i +: XLEN];
    end else begin : g_pad
      assign mask[i] = 1'b0;
    end
  end

  always_comb begin
    gprs_pad = '0;
    gprs_pad[NUM_GPRS*XLEN-1:0] = gprs;
  end

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) &&
                 (wr_q[AW-1:0] == rd_q[AW-1:0]);

  assign pop  = !empty && out_ready;
  assign enq  = commit_valid && ((DIFF_MODE == 0) || (mask != '0));
  // A pop frees the slot in the same cycle, so a full FIFO can still accept.
  assign push = enq && (!full || pop);
  assign drop = enq && full && !pop;

  assign wr_d = push ? wr_q + PW'(1) : wr_q;
  assign rd_d = pop  ? rd_q + PW'(1) : rd_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q     <= '0;
      rd_q     <= '0;
      shadow_q <= '0;
      seq_q    <= '0;
      ovf_q    <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      if (push)
        shadow_q <= gprs;
      if (commit_valid)
        seq_q <= seq_q + 32'd1;
      if (drop && (ovf_q != 16'hFFFF))
        ovf_q <= ovf_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset) begin
      gprs_mem[wr_q[AW-1:0]] <= gprs_pad;
      pc_mem[wr_q[AW-1:0]]   <= commit_pc;
      mask_mem[wr_q[AW-1:0]] <= mask;
      seq_mem[wr_q[AW-1:0]]  <= seq_q;
    end
  end

  assign out_valid    = !empty;
  assign out_gprs     = gprs_mem[rd_q[AW-1:0]];
  assign out_pc       = pc_mem[rd_q[AW-1:0]];
  assign out_mask     = mask_mem[rd_q[AW-1:0]];
  assign out_seq      = seq_mem[rd_q[AW-1:0]];
  assign count        = wr_q - rd_q;
  assign overflow_cnt = ovf_q;

endmodule

// File: tb/tb_gpr_snapshot_fifo.sv
// Bench for gpr_snapshot_fifo: a 16-GPR full-record instance and a
// 32-GPR diff-mode instance, driven by vector tables and short sequences.
module tb_gpr_snapshot_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // 16 GPRs, enqueue every commit
  logic          a_rst, a_cv, a_rdy;
  logic [31:0]   a_pc;
  logic [511:0]  a_gprs;
  logic          a_valid;
  logic [1023:0] a_gprs_o;
  logic [31:0]   a_pc_o, a_mask, a_seq;
  logic [2:0]    a_cnt;
  logic [15:0]   a_ovf;

  // 32 GPRs, diff mode
  logic          b_rst, b_cv, b_rdy;
  logic [31:0]   b_pc;
  logic [1023:0] b_gprs;
  logic          b_valid;
  logic [1023:0] b_gprs_o;
  logic [31:0]   b_pc_o, b_mask, b_seq;
  logic [2:0]    b_cnt;
  logic [15:0]   b_ovf;

  gpr_snapshot_fifo #(
    .NUM_GPRS(16), .XLEN(32), .DEPTH(4), .DIFF_MODE(0)
  ) u_a (
    .clk(clk), .reset(a_rst), .commit_valid(a_cv),
    .commit_pc(a_pc), .gprs(a_gprs), .out_valid(a_valid),
    .out_ready(a_rdy), .out_gprs(a_gprs_o), .out_pc(a_pc_o),
    .out_mask(a_mask), .out_seq(a_seq), .count(a_cnt),
    .overflow_cnt(a_ovf)
  );

  gpr_snapshot_fifo #(
    .NUM_GPRS(32), .XLEN(32), .DEPTH(4), .DIFF_MODE(1)
  ) u_b (
    .clk(clk), .reset(b_rst), .commit_valid(b_cv),
    .commit_pc(b_pc), .gprs(b_gprs), .out_valid(b_valid),
    .out_ready(b_rdy), .out_gprs(b_gprs_o), .out_pc(b_pc_o),
    .out_mask(b_mask), .out_seq(b_seq), .count(b_cnt),
    .overflow_cnt(b_ovf)
  );

  typedef struct {
    logic        cv;
    logic        rdy;
    logic [31:0] pc;
    logic [31:0] x1, x2, x3, x4;
    logic        ev;
    int          ecnt;
    int          eovf;
    logic [31:0] eseq;
    logic [31:0] emask;
    logic [31:0] epc;
    logic [31:0] ex1;
  } vec_t;

  localparam int NV = 21;
  vec_t tv [NV];

  function automatic logic [31:0] pc_of(input int k);
    return 32'h8000_0000 + 32'(4 * k);
  endfunction

  function automatic vec_t mkv(
    input logic cv, input logic rdy, input int k,
    input logic [31:0] x1, input logic [31:0] x2,
    input logic [31:0] x3, input logic [31:0] x4,
    input logic ev, input int ecnt, input int eovf,
    input int eseq, input logic [31:0] emask,
    input logic [31:0] ex1
  );
    vec_t v;
    v.cv = cv; v.rdy = rdy; v.pc = pc_of(k);
    v.x1 = x1; v.x2 = x2; v.x3 = x3; v.x4 = x4;
    v.ev = ev; v.ecnt = ecnt; v.eovf = eovf;
    v.eseq = 32'(eseq); v.emask = emask;
    v.epc = pc_of(eseq); v.ex1 = ex1;
    return v;
  endfunction

  function automatic logic [511:0] mk16(
    input logic [31:0] x1, input logic [31:0] x2,
    input logic [31:0] x3, input logic [31:0] x4
  );
    logic [511:0] g;
    g = '0;
    g[63:32] = x1; g[95:64] = x2;
    g[127:96] = x3; g[159:128] = x4;
    return g;
  endfunction

  function automatic logic [1023:0] mk32(
    input logic [31:0] x1, input logic [31:0] x31
  );
    logic [1023:0] g;
    g = '0;
    g[63:32] = x1;
    g[1023:992] = x31;
    return g;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_a;
    a_rst = 1'b1; a_cv = 1'b0; a_rdy = 1'b0;
    tick();
    a_rst = 1'b0;
  endtask

  int q[$];
  int seqm;
  int ovfm;
  logic popm;

  initial begin
    a_rst = 1'b1; a_cv = 1'b0; a_rdy = 1'b0;
    a_pc = '0; a_gprs = '0;
    b_rst = 1'b1; b_cv = 1'b0; b_rdy = 1'b0;
    b_pc = '0; b_gprs = '0;

    // 0-5 fill with out_ready low; commits 4 and 5 are dropped
    tv[0]  = mkv(1, 0, 0, 5, 0, 0, 0, 1, 1, 0, 0, 32'h2, 5);
    tv[1]  = mkv(1, 0, 1, 6, 0, 0, 0, 1, 2, 0, 0, 32'h2, 5);
    tv[2]  = mkv(1, 0, 2, 7, 0, 0, 0, 1, 3, 0, 0, 32'h2, 5);
    tv[3]  = mkv(1, 0, 3, 8, 0, 0, 0, 1, 4, 0, 0, 32'h2, 5);
    tv[4]  = mkv(1, 0, 4, 8, 1, 0, 0, 1, 4, 1, 0, 32'h2, 5);
    tv[5]  = mkv(1, 0, 5, 8, 1, 2, 0, 1, 4, 2, 0, 32'h2, 5);
    tv[6]  = mkv(0, 1, 0, 0, 0, 0, 0, 1, 3, 2, 1, 32'h2, 6);
    tv[7]  = mkv(0, 1, 0, 0, 0, 0, 0, 1, 2, 2, 2, 32'h2, 7);
    tv[8]  = mkv(0, 1, 0, 0, 0, 0, 0, 1, 1, 2, 3, 32'h2, 8);
    tv[9]  = mkv(0, 1, 0, 0, 0, 0, 0, 0, 0, 2, 0, 32'h0, 0);
    // commit 6 at empty: mask spans changes of dropped commits 4 and 5
    tv[10] = mkv(1, 1, 6, 8, 1, 2, 3, 1, 1, 2, 6, 32'h1C, 8);
    tv[11] = mkv(0, 1, 0, 0, 0, 0, 0, 0, 0, 2, 0, 32'h0, 0);
    tv[12] = mkv(1, 0, 7, 1, 0, 0, 0, 1, 1, 2, 7, 32'h1E, 1);
    tv[13] = mkv(1, 0, 8, 2, 0, 0, 0, 1, 2, 2, 7, 32'h1E, 1);
    tv[14] = mkv(1, 0, 9, 3, 0, 0, 0, 1, 3, 2, 7, 32'h1E, 1);
    tv[15] = mkv(1, 0, 10, 4, 0, 0, 0, 1, 4, 2, 7, 32'h1E, 1);
    // full with pop and push together: no drop
    tv[16] = mkv(1, 1, 11, 5, 0, 0, 0, 1, 4, 2, 8, 32'h2, 2);
    tv[17] = mkv(0, 1, 0, 0, 0, 0, 0, 1, 3, 2, 9, 32'h2, 3);
    tv[18] = mkv(0, 1, 0, 0, 0, 0, 0, 1, 2, 2, 10, 32'h2, 4);
    tv[19] = mkv(0, 1, 0, 0, 0, 0, 0, 1, 1, 2, 11, 32'h2, 5);
    tv[20] = mkv(0, 1, 0, 0, 0, 0, 0, 0, 0, 2, 0, 32'h0, 0);

    tick();
    tick();
    chk("rst_valid", a_valid, 0);
    chk("rst_count", a_cnt, 0);
    chk("rst_ovf", a_ovf, 0);
    a_rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      a_cv = tv[i].cv;
      a_rdy = tv[i].rdy;
      a_pc = tv[i].pc;
      a_gprs = mk16(tv[i].x1, tv[i].x2, tv[i].x3, tv[i].x4);
      tick();
      chk($sformatf("v%0d_valid", i), a_valid, tv[i].ev);
      chk($sformatf("v%0d_count", i), a_cnt, tv[i].ecnt);
      chk($sformatf("v%0d_ovf", i), a_ovf, tv[i].eovf);
      if (tv[i].ev) begin
        chk($sformatf("v%0d_seq", i), a_seq, tv[i].eseq);
        chk($sformatf("v%0d_mask", i), a_mask, tv[i].emask);
        chk($sformatf("v%0d_pc", i), a_pc_o, tv[i].epc);
        chk($sformatf("v%0d_x1", i), a_gprs_o[63:32], tv[i].ex1);
        chk($sformatf("v%0d_hi0", i),
            {63'd0, a_gprs_o[1023:512] == '0}, 1);
      end
    end
    a_cv = 1'b0;
    a_rdy = 1'b0;

    // pointer wrap with random out_ready against a queue model
    reset_a();
    seqm = 0;
    ovfm = 0;
    for (int i = 0; i < 24; i++) begin
      a_cv = 1'b1;
      a_rdy = 1'($urandom_range(0, 1));
      a_pc = 32'h1000 + 32'(4 * i);
      a_gprs = mk16(32'(i + 1), 0, 0, 0);
      chk("wrap_valid", a_valid, q.size() > 0);
      popm = a_rdy && (q.size() > 0);
      if (popm) begin
        chk("wrap_seq", a_seq, q[0]);
        void'(q.pop_front());
      end
      if (q.size() < 4) q.push_back(seqm);
      else ovfm++;
      seqm++;
      tick();
      chk("wrap_count", a_cnt, q.size());
      chk("wrap_ovf", a_ovf, ovfm);
    end
    a_cv = 1'b0;
    a_rdy = 1'b1;
    for (int n = 0; n < 8 && q.size() > 0; n++) begin
      chk("drain_valid", a_valid, 1);
      chk("drain_seq", a_seq, q[0]);
      void'(q.pop_front());
      tick();
    end
    chk("drain_empty", a_valid, 0);
    chk("drain_count", a_cnt, q.size());

    // reset mid-operation with 3 queued entries and a commit present
    reset_a();
    for (int i = 0; i < 5; i++) begin
      a_cv = 1'b1;
      a_rdy = 1'b0;
      a_gprs = mk16(32'(20 + i), 0, 0, 0);
      tick();
    end
    a_cv = 1'b0;
    a_rdy = 1'b1;
    tick();
    chk("pre_rst_count", a_cnt, 3);
    chk("pre_rst_ovf", a_ovf, 1);
    a_rst = 1'b1;
    a_cv = 1'b1;
    a_rdy = 1'b0;
    a_gprs = mk16(99, 0, 0, 0);
    tick();
    chk("mid_rst_valid", a_valid, 0);
    chk("mid_rst_count", a_cnt, 0);
    chk("mid_rst_ovf", a_ovf, 0);
    a_rst = 1'b0;
    a_pc = 32'h4000_0000;
    a_gprs = mk16(9, 0, 0, 0);
    tick();
    a_cv = 1'b0;
    chk("post_rst_valid", a_valid, 1);
    chk("post_rst_seq", a_seq, 0);
    chk("post_rst_mask", a_mask, 32'h2);
    chk("post_rst_pc", a_pc_o, 32'h4000_0000);

    // diff mode: identical snapshots are filtered but still consume seq
    b_rst = 1'b0;
    b_cv = 1'b1;
    b_pc = 32'h100;
    b_gprs = mk32(7, 0);
    tick();
    chk("diff_first_valid", b_valid, 1);
    chk("diff_first_seq", b_seq, 0);
    chk("diff_first_mask", b_mask, 32'h2);
    b_pc = 32'h104;
    tick();
    b_pc = 32'h108;
    tick();
    chk("diff_filter_count", b_cnt, 1);
    chk("diff_filter_ovf", b_ovf, 0);
    b_pc = 32'h10C;
    b_gprs = mk32(7, 9);
    b_rdy = 1'b1;
    tick();
    b_cv = 1'b0;
    b_rdy = 1'b0;
    chk("diff_x31_count", b_cnt, 1);
    chk("diff_x31_seq", b_seq, 3);
    chk("diff_x31_mask", b_mask, 32'h8000_0000);
    chk("diff_x31_val", b_gprs_o[1023:992], 9);
    chk("diff_x31_pc", b_pc_o, 32'h10C);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
